// File: rtl/sram_bank_arbiter_if.sv
// Requestor-side bus of the SRAM bank arbiter: NUM_CH channels packed side by side,
// channel c occupying bit c, bits [4c+3:4c] of ch_be and bits [32c+31:32c] of the 32-bit fields.
interface sram_bank_arbiter_if #(
    parameter int NUM_CH = 2
);
    logic [NUM_CH-1:0]    ch_req;
    logic [NUM_CH-1:0]    ch_we;
    logic [4*NUM_CH-1:0]  ch_be;
    logic [32*NUM_CH-1:0] ch_addr;
    logic [32*NUM_CH-1:0] ch_wdata;
    logic [NUM_CH-1:0]    ch_ack;
    logic [NUM_CH-1:0]    ch_err;
    logic [32*NUM_CH-1:0] ch_rdata;

    modport master (
        output ch_req, ch_we, ch_be, ch_addr, ch_wdata,
        input  ch_ack, ch_err, ch_rdata
    );

    modport slave (
        input  ch_req, ch_we, ch_be, ch_addr, ch_wdata,
        output ch_ack, ch_err, ch_rdata
    );
endinterface

// File: rtl/sram_bank_arbiter.sv
// Arbiter between NUM_CH requestors and the BaseRAM/ExtRAM asynchronous SRAMs, with one
// IDLE->ACCESS->DONE engine per bank so two channels can use different banks at once.
module sram_bank_arbiter #(
    parameter int          NUM_CH      = 2,
    parameter int          WAIT_CYCLES = 1,
    parameter int          ARB_MODE    = 1,
    parameter logic [31:0] RAM_BASE    = 32'h8000_0000
) (
    input  logic               clk,
    input  logic               resetn,
    sram_bank_arbiter_if.slave ch,
    output logic [19:0]        base_ram_addr,
    output logic [3:0]         base_ram_be_n,
    output logic               base_ram_ce_n,
    output logic               base_ram_oe_n,
    output logic               base_ram_we_n,
    output logic [31:0]        base_ram_data_o,
    output logic               base_ram_data_oe,
    input  logic [31:0]        base_ram_data_i,
    output logic [19:0]        ext_ram_addr,
    output logic [3:0]         ext_ram_be_n,
    output logic               ext_ram_ce_n,
    output logic               ext_ram_oe_n,
    output logic               ext_ram_we_n,
    output logic [31:0]        ext_ram_data_o,
    output logic               ext_ram_data_oe,
    input  logic [31:0]        ext_ram_data_i
);

    localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

    // First requester at or after ptr, wrapping around; ptr = 0 gives fixed priority.
    function automatic logic [NUM_CH-1:0] f_pick(input logic [NUM_CH-1:0] mask,
                                                 input logic [PTR_W-1:0]  ptr);
        logic [NUM_CH-1:0] g;
        logic              found;
        g     = '0;
        found = 1'b0;
        for (int j = 0; j < NUM_CH; j++) begin
            if (!found && (j >= int'(ptr)) && mask[j]) begin
                g[j]  = 1'b1;
                found = 1'b1;
            end
        end
        for (int j = 0; j < NUM_CH; j++) begin
            if (!found && (j < int'(ptr)) && mask[j]) begin
                g[j]  = 1'b1;
                found = 1'b1;
            end
        end
        return g;
    endfunction

    function automatic logic [PTR_W-1:0] f_enc(input logic [NUM_CH-1:0] onehot);
        logic [PTR_W-1:0] id;
        id = '0;
        for (int j = 0; j < NUM_CH; j++) begin
            if (onehot[j]) id = PTR_W'(j);
        end
        return id;
    endfunction

    logic [NUM_CH-1:0] w_inwin;
    logic [NUM_CH-1:0] w_bank;
    logic [NUM_CH-1:0] w_unmapped;

    always_comb begin
        w_inwin = '0;
        w_bank  = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            w_inwin[c] = (ch.ch_addr[c*32 +: 32] - RAM_BASE) < 32'h0080_0000;
            w_bank[c]  = ch.ch_addr[c*32 + 22];
        end
    end

    assign w_unmapped = ch.ch_req & ~w_inwin;

    // Per-bank results, index 0 = BaseRAM, 1 = ExtRAM
    logic             w_bk_fin  [2];
    logic             w_bk_rd   [2];
    logic [PTR_W-1:0] w_bk_id   [2];
    logic [31:0]      w_bk_din  [2];
    logic             w_bk_ce_n [2];
    logic             w_bk_oe_n [2];
    logic             w_bk_we_n [2];
    logic             w_bk_doe  [2];
    logic [3:0]       w_bk_be_n [2];
    logic [19:0]      w_bk_addr [2];
    logic [31:0]      w_bk_dout [2];

    assign w_bk_din[0] = base_ram_data_i;
    assign w_bk_din[1] = ext_ram_data_i;

    for (genvar b = 0; b < 2; b++) begin : g_bank
        state_t            r_state;
        state_t            w_next;
        logic [2:0]        r_cnt;
        logic [PTR_W-1:0]  r_ptr;
        logic [PTR_W-1:0]  r_gid;
        logic [PTR_W-1:0]  w_gnt_id;
        logic [19:0]       r_addr;
        logic [19:0]       w_sel_addr;
        logic [3:0]        r_be;
        logic [3:0]        w_sel_be;
        logic              r_we;
        logic              w_sel_we;
        logic [31:0]       r_wdata;
        logic [31:0]       w_sel_wdata;
        logic [NUM_CH-1:0] w_cand;
        logic [NUM_CH-1:0] w_grant;
        logic              w_last;
        logic              w_ce_n;
        logic              w_oe_n;
        logic              w_we_n;
        logic              w_doe;
        logic [3:0]        w_be_n;

        assign w_cand   = ch.ch_req & w_inwin & ((b == 0) ? ~w_bank : w_bank);
        assign w_grant  = f_pick(w_cand, (ARB_MODE == 1) ? r_ptr : PTR_W'(0));
        assign w_gnt_id = f_enc(w_grant);
        assign w_last   = (r_state == S_ACCESS) && (r_cnt == 3'(WAIT_CYCLES));

        always_comb begin
            w_sel_addr  = '0;
            w_sel_be    = '0;
            w_sel_we    = 1'b0;
            w_sel_wdata = '0;
            for (int c = 0; c < NUM_CH; c++) begin
                if (w_grant[c]) begin
                    w_sel_addr  = ch.ch_addr[c*32 + 2 +: 20];
                    w_sel_be    = ch.ch_be[c*4 +: 4];
                    w_sel_we    = ch.ch_we[c];
                    w_sel_wdata = ch.ch_wdata[c*32 +: 32];
                end
            end
        end

        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) r_state <= S_IDLE;
            else         r_state <= w_next;
        end

        always_comb begin
            w_next = r_state;
            case (r_state)
                S_IDLE:   if (|w_cand) w_next = S_ACCESS;
                S_ACCESS: if (w_last)  w_next = S_DONE;
                S_DONE:   w_next = S_IDLE;
                default:  w_next = S_IDLE;
            endcase
        end

        // Latch the granted request; the access runs to completion even if req drops
        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                r_cnt   <= '0;
                r_ptr   <= '0;
                r_gid   <= '0;
                r_addr  <= '0;
                r_be    <= '0;
                r_we    <= 1'b0;
                r_wdata <= '0;
            end else if (r_state == S_IDLE) begin
                r_cnt <= '0;
                if (|w_cand) begin
                    r_gid   <= w_gnt_id;
                    r_ptr   <= (w_gnt_id == PTR_W'(NUM_CH - 1)) ? '0 : w_gnt_id + 1'b1;
                    r_addr  <= w_sel_addr;
                    r_be    <= w_sel_be;
                    r_we    <= w_sel_we;
                    r_wdata <= w_sel_wdata;
                end
            end else if (r_state == S_ACCESS) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end

        always_comb begin
            w_ce_n = 1'b1;
            w_oe_n = 1'b1;
            w_we_n = 1'b1;
            w_be_n = 4'hF;
            w_doe  = 1'b0;
            case (r_state)
                S_ACCESS: begin
                    w_ce_n = 1'b0;
                    w_oe_n = r_we;
                    w_we_n = ~r_we;
                    w_be_n = r_we ? ~r_be : 4'h0;
                    w_doe  = r_we;
                end
                S_DONE:  w_doe = r_we;  // keep driving the pad for write hold time
                default: ;
            endcase
        end

        assign w_bk_fin[b]  = w_last;
        assign w_bk_rd[b]   = ~r_we;
        assign w_bk_id[b]   = r_gid;
        assign w_bk_ce_n[b] = w_ce_n;
        assign w_bk_oe_n[b] = w_oe_n;
        assign w_bk_we_n[b] = w_we_n;
        assign w_bk_doe[b]  = w_doe;
        assign w_bk_be_n[b] = w_be_n;
        assign w_bk_addr[b] = r_addr;
        assign w_bk_dout[b] = r_wdata;
    end

    logic [NUM_CH-1:0] r_ack;
    logic [NUM_CH-1:0] r_err;
    logic [31:0]       r_rdata [NUM_CH];

    // Unmapped requests are acked once; the ~r_ack mask stops a re-ack while req is still held
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_ack <= '0;
            r_err <= '0;
            for (int c = 0; c < NUM_CH; c++) r_rdata[c] <= '0;
        end else begin
            r_ack <= w_unmapped & ~r_ack;
            r_err <= w_unmapped & ~r_ack;
            for (int b = 0; b < 2; b++) begin
                if (w_bk_fin[b]) begin
                    r_ack[w_bk_id[b]] <= 1'b1;
                    if (w_bk_rd[b]) r_rdata[w_bk_id[b]] <= w_bk_din[b];
                end
            end
        end
    end

    assign ch.ch_ack = r_ack;
    assign ch.ch_err = r_err;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_rdata
        assign ch.ch_rdata[c*32 +: 32] = r_rdata[c];
    end

    assign base_ram_addr    = w_bk_addr[0];
    assign base_ram_be_n    = w_bk_be_n[0];
    assign base_ram_ce_n    = w_bk_ce_n[0];
    assign base_ram_oe_n    = w_bk_oe_n[0];
    assign base_ram_we_n    = w_bk_we_n[0];
    assign base_ram_data_o  = w_bk_dout[0];
    assign base_ram_data_oe = w_bk_doe[0];

    assign ext_ram_addr     = w_bk_addr[1];
    assign ext_ram_be_n     = w_bk_be_n[1];
    assign ext_ram_ce_n     = w_bk_ce_n[1];
    assign ext_ram_oe_n     = w_bk_oe_n[1];
    assign ext_ram_we_n     = w_bk_we_n[1];
    assign ext_ram_data_o   = w_bk_dout[1];
    assign ext_ram_data_oe  = w_bk_doe[1];

endmodule
